alu_sequencer: RTL

//  Issuing side of the ALU interface: accepts one instruction per valid/ready handshake.

---
 rtl/alu_sequencer_pkg.sv | 38 +++
 rtl/alu_sequencer_if.sv | 40 ++++
 rtl/alu_sequencer_decode.sv | 25 ++
 rtl/alu_sequencer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared types and constants for the ALU issue sequencer: ALU op codes, opcodes,
// FSM states and the decoded-control bundle.
package alu_sequencer_pkg;

  localparam int DATA_BUS_WIDTH = 16;

  localparam logic [2:0] ALU_OP_NOP = 3'd0;
  localparam logic [2:0] ALU_OP_ADD = 3'd1;
  localparam logic [2:0] ALU_OP_SUB = 3'd2;

  localparam logic [3:0] OPC_ADD  = 4'd0;
  localparam logic [3:0] OPC_SUB  = 4'd1;
  localparam logic [3:0] OPC_CMP  = 4'd2;
  localparam logic [3:0] OPC_ADDI = 4'd3;
  localparam logic [3:0] OPC_MOV  = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // Source of the second ALU operand.
  typedef enum logic [1:0] {
    B_SEL_RF   = 2'd0,
    B_SEL_IMM  = 2'd1,
    B_SEL_ZERO = 2'd2
  } b_sel_e;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       writes_rd;
    b_sel_e     b_sel;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Bus bundle between the sequencer and its environment: instruction handshake,
// register-file read/write ports and the ALU operand/result port.
interface alu_sequencer_if
  import alu_sequencer_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int INSTR_W    = 16
);

  logic                      instr_valid;
  logic                      instr_ready;
  logic [INSTR_W-1:0]        instr;

  logic [REG_ADDR_W-1:0]     rf_ra_addr;
  logic [REG_ADDR_W-1:0]     rf_rb_addr;
  logic [DATA_BUS_WIDTH-1:0] rf_ra_data;
  logic [DATA_BUS_WIDTH-1:0] rf_rb_data;
  logic                      rf_we;
  logic [REG_ADDR_W-1:0]     rf_wa;
  logic [DATA_BUS_WIDTH-1:0] rf_wd;

  logic [DATA_BUS_WIDTH-1:0] Alu_A;
  logic [DATA_BUS_WIDTH-1:0] Alu_B;
  logic [2:0]                Alu_Op;
  logic [DATA_BUS_WIDTH-1:0] Alu_Result;
  logic                      Alu_Z;

  modport master (
    input  instr_valid, instr, rf_ra_data, rf_rb_data, Alu_Result, Alu_Z,
    output instr_ready, rf_ra_addr, rf_rb_addr, rf_we, rf_wa, rf_wd,
           Alu_A, Alu_B, Alu_Op
  );

  modport slave (
    output instr_valid, instr, rf_ra_data, rf_rb_data, Alu_Result, Alu_Z,
    input  instr_ready, rf_ra_addr, rf_rb_addr, rf_we, rf_wa, rf_wd,
           Alu_A, Alu_B, Alu_Op
  );

endinterface

// File: rtl/alu_sequencer_decode.sv
// Combinational opcode decoder. Define ALU_SEQ_CMP_EN to make opcode 2 (CMP) a
// flag-only SUB; otherwise it decodes as illegal.
module alu_seq_decode
  import alu_sequencer_pkg::*;
(
  input  logic [3:0] opc_i,
  output dec_t       dec_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    dec_o = '{alu_op: ALU_OP_NOP, writes_rd: 1'b0, b_sel: B_SEL_RF, illegal: 1'b1};
    case (opc_i)
      OPC_ADD:  dec_o = '{alu_op: ALU_OP_ADD, writes_rd: 1'b1, b_sel: B_SEL_RF,   illegal: 1'b0};
      OPC_SUB:  dec_o = '{alu_op: ALU_OP_SUB, writes_rd: 1'b1, b_sel: B_SEL_RF,   illegal: 1'b0};
`ifdef ALU_SEQ_CMP_EN
      OPC_CMP:  dec_o = '{alu_op: ALU_OP_SUB, writes_rd: 1'b0, b_sel: B_SEL_RF,   illegal: 1'b0};
`endif
      OPC_ADDI: dec_o = '{alu_op: ALU_OP_ADD, writes_rd: 1'b1, b_sel: B_SEL_IMM,  illegal: 1'b0};
      OPC_MOV:  dec_o = '{alu_op: ALU_OP_ADD, writes_rd: 1'b1, b_sel: B_SEL_ZERO, illegal: 1'b0};
      default:  ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Non-pipelined ALU issue sequencer: IDLE->READ->EXEC->WB, one instruction per
// four cycles. Optional CMP support is enabled by defining ALU_SEQ_CMP_EN.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int INSTR_W    = 16
)(
  input  logic             clk,
  input  logic             reset,
  alu_sequencer_if.master  bus,
  output logic             z_flag,
  output logic             done,
  output logic             illegal
);

  state_e                    state_q, state_d;
  logic [3:0]                opc_q, opc_d;
  logic [REG_ADDR_W-1:0]     rd_q, rd_d;
  logic [REG_ADDR_W-1:0]     ra_addr_q, ra_addr_d;
  logic [REG_ADDR_W-1:0]     rb_addr_q, rb_addr_d;
  logic [DATA_BUS_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_BUS_WIDTH-1:0] op_b_q, op_b_d;
  logic [DATA_BUS_WIDTH-1:0] res_q, res_d;
  logic                      z_cap_q, z_cap_d;
  logic                      z_flag_q, z_flag_d;

  logic                      accept;
  dec_t                      dec;

  logic [3:0]                instr_opc;
  logic [REG_ADDR_W-1:0]     instr_rd, instr_rs, instr_rt;

  assign instr_opc = bus.instr[INSTR_W-1 -: 4];
  assign instr_rd  = bus.instr[3*REG_ADDR_W-1 -: REG_ADDR_W];
  assign instr_rs  = bus.instr[2*REG_ADDR_W-1 -: REG_ADDR_W];
  assign instr_rt  = bus.instr[REG_ADDR_W-1:0];

  assign accept = (state_q == ST_IDLE) && bus.instr_valid;

  alu_seq_decode u_decode (
    .opc_i (opc_q),
    .dec_o (dec)
  );

  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    rd_d      = rd_q;
    ra_addr_d = ra_addr_q;
    rb_addr_d = rb_addr_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    res_d     = res_q;
    z_cap_d   = z_cap_q;
    z_flag_d  = z_flag_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid) begin
          opc_d     = instr_opc;
          rd_d      = instr_rd;
          ra_addr_d = instr_rs;
          rb_addr_d = instr_rt;
          state_d   = ST_READ;
        end
      end
      ST_READ: begin
        op_a_d = bus.rf_ra_data;
        unique case (dec.b_sel)
          B_SEL_IMM:  op_b_d = {{(DATA_BUS_WIDTH-REG_ADDR_W){1'b0}}, rb_addr_q};
          B_SEL_ZERO: op_b_d = '0;
          default:    op_b_d = bus.rf_rb_data;
        endcase
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        res_d   = bus.Alu_Result;
        z_cap_d = bus.Alu_Z;
        state_d = ST_WB;
      end
      ST_WB: begin
        // Z comes straight from the ALU; it is never rederived from the result.
        if (!dec.illegal) z_flag_d = z_cap_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: datapath registers are reset as well because they are visible on the bus.
      state_q   <= ST_IDLE;
      opc_q     <= '0;
      rd_q      <= '0;
      ra_addr_q <= '0;
      rb_addr_q <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      res_q     <= '0;
      z_cap_q   <= 1'b0;
      z_flag_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      opc_q     <= opc_d;
      rd_q      <= rd_d;
      ra_addr_q <= ra_addr_d;
      rb_addr_q <= rb_addr_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      res_q     <= res_d;
      z_cap_q   <= z_cap_d;
      z_flag_q  <= z_flag_d;
    end
  end

  // Register file reads are synchronous, so the address goes out in the accept cycle.
  assign bus.rf_ra_addr  = accept ? instr_rs : ra_addr_q;
  assign bus.rf_rb_addr  = accept ? instr_rt : rb_addr_q;

  assign bus.instr_ready = (state_q == ST_IDLE);
  assign bus.Alu_A       = op_a_q;
  assign bus.Alu_B       = op_b_q;
  assign bus.Alu_Op      = (state_q == ST_EXEC) ? dec.alu_op : ALU_OP_NOP;

  // Retire strobes are masked by reset so an abandoned instruction never commits.
  assign bus.rf_we = (state_q == ST_WB) && dec.writes_rd && !reset;
  assign bus.rf_wa = rd_q;
  assign bus.rf_wd = res_q;
  assign done      = (state_q == ST_WB) && !reset;
  assign illegal   = (state_q == ST_WB) && dec.illegal && !reset;
  assign z_flag    = z_flag_q;

endmodule
